// File: rtl/dct_fifo_pkg.sv
// Shared constants and helpers for the batch-write / serial-read DCT FIFO family.
package dct_fifo_pkg;
  localparam int unsigned DEF_DATA_W = 36;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned SLOTS      = DEF_DEPTH / DEF_LANES;

  // Index width that never collapses to zero bits for tiny ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

`ifndef DCT_FIFO_LANE
`define DCT_FIFO_LANE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

// File: rtl/batch_fifo_param_if.sv
// Handshake/status bundle for batch_fifo_param; watermark signals exist only with BATCH_FIFO_WATERMARK_EN.
interface batch_fifo_param_if
  import dct_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned DEPTH  = DEF_DEPTH
) ();
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned N_SLOTS = DEPTH / LANES;

  logic                    wr_en;
  logic [LANES*DATA_W-1:0] din;
  logic                    wr_ready;
  logic                    rd_en;
  logic [DATA_W-1:0]       dout;
  logic                    dout_valid;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;
  logic [N_SLOTS-1:0]      slot_full;
  logic                    overflow;
  logic                    underflow;
`ifdef BATCH_FIFO_WATERMARK_EN
  logic                    almost_full;
  logic                    almost_empty;
`endif

  modport master (
    output wr_en, din, rd_en,
    input  wr_ready, dout, dout_valid, count, full, empty, slot_full, overflow, underflow
`ifdef BATCH_FIFO_WATERMARK_EN
    , input almost_full, almost_empty
`endif
  );

  modport slave (
    input  wr_en, din, rd_en,
    output wr_ready, dout, dout_valid, count, full, empty, slot_full, overflow, underflow
`ifdef BATCH_FIFO_WATERMARK_EN
    , output almost_full, almost_empty
`endif
  );
endinterface

// File: rtl/batch_fifo_mem.sv
// Simple dual-port RAM: LANES-wide aligned write port, one-word registered read port.
module batch_fifo_mem
  import dct_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]       rd_data
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // wr_addr is LANES-aligned, so a batch never wraps past the end of the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        mem[wr_addr + PTR_W'(i)] <= `DCT_FIFO_LANE(wr_data, i, DATA_W);
      end
    end
  end

  // Only the output register is reset; the array contents are left untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/batch_fifo_param.sv
// Parametrised batch-write / serial-read FIFO control; BATCH_FIFO_WATERMARK_EN adds almost_full/almost_empty.
module batch_fifo_param
  import dct_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  batch_fifo_param_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LANE_W  = $clog2(LANES);
  localparam int unsigned N_SLOTS = DEPTH / LANES;
  localparam int unsigned SLOT_W  = clog2_min1(N_SLOTS);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LANE_MASK = PTR_W'(LANES - 1);

  if (((DEPTH & (DEPTH - 1)) != 0) || ((DEPTH % LANES) != 0) || (DEPTH < 2 * LANES)) begin : g_bad_depth
    $error("batch_fifo_param: DEPTH must be a power of 2, a multiple of LANES and >= 2*LANES");
  end
  if ((LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("batch_fifo_param: LANES must be a power of 2");
  end

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic [N_SLOTS-1:0] slot_full, slot_next;
  logic               dout_valid, overflow, underflow;
  logic               wr_ready, full, empty, wr_acc, rd_acc;
  logic [SLOT_W-1:0]  wr_slot, rd_slot;

  assign wr_ready = (count <= CNT_W'(DEPTH - LANES));
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign wr_acc   = bus.wr_en && wr_ready && !flush;
  assign rd_acc   = bus.rd_en && !empty && !flush;
  assign wr_slot  = SLOT_W'(wr_ptr >> LANE_W);
  assign rd_slot  = SLOT_W'(rd_ptr >> LANE_W);

  always_comb begin
    count_next = count;
    if (wr_acc) count_next = count_next + CNT_W'(LANES);
    if (rd_acc) count_next = count_next - CNT_W'(1);
  end

  // Clear-before-set: a free write slot can never be the slot a read is finishing.
  always_comb begin
    slot_next = slot_full;
    if (rd_acc && ((rd_ptr & LANE_MASK) == LANE_MASK)) slot_next[rd_slot] = 1'b0;
    if (wr_acc) slot_next[wr_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_full  <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_full  <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(LANES);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      slot_full  <= slot_next;
      dout_valid <= rd_acc;
      if (bus.wr_en && !wr_ready) overflow  <= 1'b1;
      if (bus.rd_en && empty)     underflow <= 1'b1;
    end
  end

`ifdef BATCH_FIFO_WATERMARK_EN
  logic almost_full, almost_empty;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= CNT_W'(AF_LEVEL));
      almost_empty <= (count_next <= CNT_W'(AE_LEVEL));
    end
  end

  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;
`endif

  batch_fifo_mem #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.din),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (bus.dout)
  );

  assign bus.wr_ready   = wr_ready;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count;
  assign bus.slot_full  = slot_full;
  assign bus.dout_valid = dout_valid;
  assign bus.overflow   = overflow;
  assign bus.underflow  = underflow;
endmodule

// File: tb/tb_batch_fifo_param.sv
// Self-checking bench for batch_fifo_param against a queue-based reference model.
module tb_batch_fifo_param;
  localparam int DATA_W = 36;
  localparam int LANES  = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  batch_fifo_param_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  batch_fifo_param #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .DEPTH    (DEPTH),
    .AF_LEVEL (12),
    .AE_LEVEL (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] q[$];
  int                rd_total = 0;
  logic [DATA_W-1:0] m_dout   = '0;
  bit                m_valid  = 0;
  bit                m_ovf    = 0;
  bit                m_udf    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [DEPTH/LANES-1:0] ms;
    int n;
    ms = '0;
    n = q.size();
    for (int j = 0; j < n; j++) ms[((rd_total + j) % DEPTH) / LANES] = 1'b1;
    check({ph, ".count"},      64'(bus.count),      64'(n));
    check({ph, ".empty"},      64'(bus.empty),      64'(n == 0));
    check({ph, ".full"},       64'(bus.full),       64'(n == DEPTH));
    check({ph, ".wr_ready"},   64'(bus.wr_ready),   64'((DEPTH - n) >= LANES));
    check({ph, ".dout_valid"}, 64'(bus.dout_valid), 64'(m_valid));
    check({ph, ".dout"},       64'(bus.dout),       64'(m_dout));
    check({ph, ".slot_full"},  64'(bus.slot_full),  64'(ms));
    check({ph, ".overflow"},   64'(bus.overflow),   64'(m_ovf));
    check({ph, ".underflow"},  64'(bus.underflow),  64'(m_udf));
`ifdef BATCH_FIFO_WATERMARK_EN
    check({ph, ".almost_full"},  64'(bus.almost_full),  64'(n >= 12));
    check({ph, ".almost_empty"}, 64'(bus.almost_empty), 64'(n <= 4));
`endif
  endtask

  // One clock: drive inputs, advance the model with the pre-edge occupancy, compare after the edge.
  task automatic step(input string ph, input bit wr, input bit rd, input bit fl, input bit rs,
                      input logic [LANES*DATA_W-1:0] d);
    int pre;
    bit wr_ok, rd_ok;
    bus.wr_en = wr; bus.rd_en = rd; bus.din = d; flush = fl; rst = rs;
    @(posedge clk);
    pre = q.size();
    if (!rs) begin
      q.delete(); rd_total = 0; m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    end else if (fl) begin
      q.delete(); rd_total = 0; m_valid = 0;
    end else begin
      wr_ok = wr && ((DEPTH - pre) >= LANES);
      rd_ok = rd && (pre > 0);
      if (wr && !wr_ok) m_ovf = 1;
      if (rd && !rd_ok) m_udf = 1;
      if (rd_ok) begin m_dout = q.pop_front(); rd_total++; end
      m_valid = rd_ok;
      if (wr_ok) for (int i = 0; i < LANES; i++) q.push_back(d[i*DATA_W +: DATA_W]);
    end
    #1;
    check_all(ph);
  endtask

  function automatic logic [LANES*DATA_W-1:0] seq_batch(input int base);
    logic [LANES*DATA_W-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*DATA_W +: DATA_W] = DATA_W'(base + i);
    return b;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] rand_batch();
    logic [LANES*DATA_W-1:0] b;
    logic [63:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = {$urandom(), $urandom()};
      b[i*DATA_W +: DATA_W] = r[DATA_W-1:0];
    end
    return b;
  endfunction

  initial begin
    int written;
    int guard;
    bit w, r;
    bus.wr_en = 0; bus.rd_en = 0; bus.din = '0;

    step("reset", 0, 0, 0, 0, '0);
    step("reset", 0, 0, 0, 0, '0);
    check("reset.empty_const", 64'(bus.empty), 64'(1));
    check("reset.wr_ready_const", 64'(bus.wr_ready), 64'(1));

    for (int b = 0; b < 4; b++) step("fill", 1, 0, 0, 1, seq_batch(4 * b));
    check("fill.full_const", 64'(bus.full), 64'(1));
    check("fill.slot_const", 64'(bus.slot_full), 64'(4'b1111));

    step("overflow", 1, 0, 0, 1, seq_batch(99) & {LANES{36'h0}} | {LANES{36'd99}});
    check("overflow.flag_const", 64'(bus.overflow), 64'(1));
    step("overflow.sticky", 0, 0, 0, 1, '0);

    for (int i = 0; i < 16; i++) begin
      step("drain", 0, 1, 0, 1, '0);
      check("drain.order", 64'(bus.dout), 64'(i));
    end
    step("drain.idle", 0, 0, 0, 1, '0);
    check("drain.slot_const", 64'(bus.slot_full), 64'(0));

    step("underflow", 0, 1, 0, 1, '0);
    check("underflow.flag_const", 64'(bus.underflow), 64'(1));

    for (int b = 0; b < 3; b++) step("fill12", 1, 0, 0, 1, seq_batch(100 + 4 * b));
    step("simul", 1, 1, 0, 1, seq_batch(112));
    check("simul.count_const", 64'(bus.count), 64'(15));
    check("simul.oldest", 64'(bus.dout), 64'(100));
    step("simul.next", 0, 0, 0, 1, '0);
    check("simul.wr_ready_const", 64'(bus.wr_ready), 64'(0));
    for (int i = 0; i < 15; i++) step("simul.drain", 0, 1, 0, 1, '0);

    step("wrap.reset", 0, 0, 0, 0, '0);
    written = 0;
    guard = 0;
    while (written < 40 && guard < 2000) begin
      w = (DEPTH - q.size()) >= LANES;
      r = q.size() > 0;
      step("wrap", w, r, 0, 1, rand_batch());
      if (w) written++;
      guard++;
    end
    check("wrap.completed", 64'(written), 64'(40));
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      step("wrap.drain", 0, 1, 0, 1, '0);
      guard++;
    end
    check("wrap.overflow_const", 64'(bus.overflow), 64'(0));
    check("wrap.underflow_const", 64'(bus.underflow), 64'(0));

    for (int i = 0; i < 300; i++) begin
      step("random", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 31) == 0, 1, rand_batch());
    end

    step("flush.reset", 0, 0, 0, 0, '0);
    step("flush.fill", 1, 0, 0, 1, seq_batch(200));
    step("flush.fill", 1, 0, 0, 1, seq_batch(204));
    step("flush", 1, 1, 1, 1, seq_batch(208));
    check("flush.count_const", 64'(bus.count), 64'(0));
    check("flush.overflow_const", 64'(bus.overflow), 64'(0));
    step("midrst.fill", 1, 0, 0, 1, seq_batch(300));
    step("midrst.fill", 1, 1, 0, 1, seq_batch(304));
    step("midrst", 1, 0, 0, 0, seq_batch(308));
    check("midrst.empty_const", 64'(bus.empty), 64'(1));
    check("midrst.valid_const", 64'(bus.dout_valid), 64'(0));
    step("midrst.after", 0, 0, 0, 1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
